// File: rtl/obuf_maxpool_reader.sv
// obuf_maxpool_reader
//
// Sweeps every non-overlapping 2x2 window of the feature-map tile held in the
// output buffer's 32-entry register files. All lanes are read in lockstep. The
// four returned values per lane are reduced to their signed maximum. Each pooled
// lane vector leaves on a valid/ready stream.
//
// Build option:
//   OBUF_POOL_RELU_EN  When defined, each lane result is clamped to zero if it is
//                      negative (ReLU fused after the max). Address generation,
//                      timing and handshake are the same in both builds.
//
// Parameters:
//   width       number of lanes (register files)
//   data_width  element width, two's-complement signed
//   MAP_W       tile row length in entries. It must be even and divide 32, and
//               32/MAP_W must be even.
//
// Ports:
//   clk            rising-edge clock
//   nrst           synchronous active-low reset
//   start          one-cycle request to pool the resident tile
//   busy           high from the cycle after an accepted start through the done cycle
//   done           one-cycle pulse after the last pooled vector is accepted
//   add_1..add_4   per-lane read addresses, lane i at [5*i +: 5], same value on all lanes
//   out1..out4     per-lane read data, lane i at [data_width*i +: data_width]
//   pool_data      pooled vector, same lane packing as out1..out4
//   pool_valid     pooled vector valid
//   pool_ready     downstream accept
//   pool_last      marks the final window of the tile

module obuf_maxpool_reader #(
  parameter int unsigned width      = 32,
  parameter int unsigned data_width = 8,
  parameter int unsigned MAP_W      = 8
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [5*width-1:0]          add_1,
  output logic [5*width-1:0]          add_2,
  output logic [5*width-1:0]          add_3,
  output logic [5*width-1:0]          add_4,
  input  logic [data_width*width-1:0] out1,
  input  logic [data_width*width-1:0] out2,
  input  logic [data_width*width-1:0] out3,
  input  logic [data_width*width-1:0] out4,
  output logic [data_width*width-1:0] pool_data,
  output logic                        pool_valid,
  input  logic                        pool_ready,
  output logic                        pool_last
);

  // Tile geometry
  localparam int unsigned MapH  = 32 / MAP_W;
  localparam int unsigned HalfW = MAP_W / 2;
  localparam int unsigned NWin  = (MapH / 2) * HalfW;
  localparam int unsigned WinW  = (NWin > 1) ? $clog2(NWin) : 1;
  localparam int unsigned ColW  = (HalfW > 1) ? $clog2(HalfW) : 1;

  localparam logic [WinW-1:0] LastWin = WinW'(NWin - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(HalfW - 1);

  // Step from one window base to the next one in the same row-pair is 2. At the
  // end of a row-pair the step is 2 + MAP_W: the window skips the odd row that
  // the current windows already cover.
  localparam logic [4:0] ColStep = 5'd2;
  localparam logic [4:0] RowStep = 5'(MAP_W + 2);
  localparam logic [4:0] Off3    = 5'(MAP_W);
  localparam logic [4:0] Off4    = 5'(MAP_W + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [WinW-1:0]             win_q, win_d;
  logic [ColW-1:0]             col_q, col_d;
  logic [4:0]                  a1_q, a1_d;
  logic [4:0]                  a2_q, a2_d;
  logic [4:0]                  a3_q, a3_d;
  logic [4:0]                  a4_q, a4_d;
  logic [data_width*width-1:0] data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        done_q, done_d;

  logic                        cap;
  logic                        hs;
  logic                        last_win;
  logic [4:0]                  step;
  logic [data_width*width-1:0] lane_max;

  // Signed maximum of two elements. Ties return either value, and both are identical.
  function automatic logic [data_width-1:0] smax(input logic [data_width-1:0] a,
                                                 input logic [data_width-1:0] b);
    smax = ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Per-lane 4:1 max reduction. An optional ReLU clamp follows the max.
  for (genvar i = 0; i < width; i++) begin : g_lane
    logic [data_width-1:0] m12;
    logic [data_width-1:0] m34;
    logic [data_width-1:0] m;

    assign m12 = smax(out1[i*data_width +: data_width], out2[i*data_width +: data_width]);
    assign m34 = smax(out3[i*data_width +: data_width], out4[i*data_width +: data_width]);
    assign m   = smax(m12, m34);
`ifdef OBUF_POOL_RELU_EN
    assign lane_max[i*data_width +: data_width] = m[data_width-1] ? '0 : m;
`else
    assign lane_max[i*data_width +: data_width] = m;
`endif
  end

  // A new vector may be captured when the output slot is empty or is being drained now.
  assign cap      = !valid_q || pool_ready;
  assign hs       = valid_q && pool_ready;
  assign last_win = (win_q == LastWin);
  assign step     = (col_q == LastCol) ? RowStep : ColStep;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    col_d   = col_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    a4_d    = a4_q;
    data_d  = data_q;
    // A handshake that is not replaced by a fresh capture empties the output slot.
    valid_d = valid_q && !pool_ready;
    last_d  = last_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        // Keep window 0 preloaded, so that its addresses are valid in the first RUN cycle.
        win_d = '0;
        col_d = '0;
        a1_d  = 5'd0;
        a2_d  = 5'd1;
        a3_d  = Off3;
        a4_d  = Off4;
        // In the done cycle the tile is still being closed out, so a start is dropped.
        if (start && !done_q) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (cap) begin
          data_d  = lane_max;
          valid_d = 1'b1;
          last_d  = last_win;
          if (last_win) begin
            state_d = StFlush;
          end else begin
            win_d = win_q + 1'b1;
            col_d = (col_q == LastCol) ? '0 : col_q + 1'b1;
            a1_d  = a1_q + step;
            a2_d  = a2_q + step;
            a3_d  = a3_q + step;
            a4_d  = a4_q + step;
          end
        end
      end

      StFlush: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      win_q   <= '0;
      col_q   <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      a4_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      col_q   <= col_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      a3_q    <= a3_d;
      a4_q    <= a4_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // The same address goes to every lane.
  assign add_1      = {width{a1_q}};
  assign add_2      = {width{a2_q}};
  assign add_3      = {width{a3_q}};
  assign add_4      = {width{a4_q}};
  assign pool_data  = data_q;
  assign pool_valid = valid_q;
  assign pool_last  = last_q;
  assign done       = done_q;
  // Busy also covers the done cycle, so busy falls only after done.
  assign busy       = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_obuf_maxpool_reader.sv
// Testbench for obuf_maxpool_reader. Two instances are built with 4 lanes each.
// Instance 0 uses MAP_W=8 and instance 1 uses MAP_W=4. The register files are
// modelled as arrays here. Expected pooled vectors come from the window
// geometry formula applied directly to those arrays.

module tb_obuf_maxpool_reader;

  logic clk = 1'b0;
  logic nrst;
  logic [1:0] start_r;
  logic [1:0] ready_r;

  logic [1:0]        busy_w, done_w, valid_w, last_w;
  logic [1:0][19:0]  a1_w, a2_w, a3_w, a4_w;
  logic [1:0][31:0]  o1_w, o2_w, o3_w, o4_w;
  logic [1:0][31:0]  data_w;

  logic [7:0] rf [2][32][4];
  logic [31:0] got[$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  obuf_maxpool_reader #(.width(4), .data_width(8), .MAP_W(8)) u_dut0 (
    .clk(clk), .nrst(nrst), .start(start_r[0]), .busy(busy_w[0]), .done(done_w[0]),
    .add_1(a1_w[0]), .add_2(a2_w[0]), .add_3(a3_w[0]), .add_4(a4_w[0]),
    .out1(o1_w[0]), .out2(o2_w[0]), .out3(o3_w[0]), .out4(o4_w[0]),
    .pool_data(data_w[0]), .pool_valid(valid_w[0]), .pool_ready(ready_r[0]),
    .pool_last(last_w[0])
  );

  obuf_maxpool_reader #(.width(4), .data_width(8), .MAP_W(4)) u_dut1 (
    .clk(clk), .nrst(nrst), .start(start_r[1]), .busy(busy_w[1]), .done(done_w[1]),
    .add_1(a1_w[1]), .add_2(a2_w[1]), .add_3(a3_w[1]), .add_4(a4_w[1]),
    .out1(o1_w[1]), .out2(o2_w[1]), .out3(o3_w[1]), .out4(o4_w[1]),
    .pool_data(data_w[1]), .pool_valid(valid_w[1]), .pool_ready(ready_r[1]),
    .pool_last(last_w[1])
  );

  // Combinational register-file reads
  for (genvar d = 0; d < 2; d++) begin : g_rf
    for (genvar l = 0; l < 4; l++) begin : g_ln
      assign o1_w[d][l*8 +: 8] = rf[d][a1_w[d][l*5 +: 5]][l];
      assign o2_w[d][l*8 +: 8] = rf[d][a2_w[d][l*5 +: 5]][l];
      assign o3_w[d][l*8 +: 8] = rf[d][a3_w[d][l*5 +: 5]][l];
      assign o4_w[d][l*8 +: 8] = rf[d][a4_w[d][l*5 +: 5]][l];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] rep5(input int v);
    logic [4:0] a;
    a = 5'(v);
    return {4{a}};
  endfunction

  // Reference: pooled vector for window w of instance d
  function automatic logic [31:0] exp_vec(input int d, input int w);
    int mapw, r, c, b, m, v;
    int offs[4];
    logic [31:0] res;
    mapw = (d == 0) ? 8 : 4;
    r = w / (mapw / 2);
    c = w % (mapw / 2);
    b = 2 * r * mapw + 2 * c;
    offs = '{0, 1, mapw, mapw + 1};
    res = '0;
    for (int l = 0; l < 4; l++) begin
      m = -1000;
      for (int k = 0; k < 4; k++) begin
        v = int'($signed(rf[d][b + offs[k]][l]));
        if (v > m) m = v;
      end
`ifdef OBUF_POOL_RELU_EN
      if (m < 0) m = 0;
`endif
      res[l*8 +: 8] = 8'(m);
    end
    return res;
  endfunction

  task automatic fill_index(input int d);
    for (int k = 0; k < 32; k++)
      for (int l = 0; l < 4; l++) rf[d][k][l] = 8'(k);
  endtask

  task automatic fill_random(input int d);
    for (int k = 0; k < 32; k++)
      for (int l = 0; l < 4; l++) rf[d][k][l] = 8'($urandom);
  endtask

  // mode 0: ready high; 1: ready low at t=2..4; 2: random ready.
  // restart: also pulse start at t=3 and on the done cycle.
  task automatic run_tile(input int d, input int mode, input bit restart);
    int mapw, nwin, nvec, stalls, t, last_t;
    bit was_stall, finished;
    logic [31:0] held_data;
    logic [19:0] held_a1;
    logic held_last;
    mapw = (d == 0) ? 8 : 4;
    nwin = ((32 / mapw) / 2) * (mapw / 2);
    got.delete();
    ready_r[d] = 1'b1;
    start_r[d] = 1'b1;
    tick();
    start_r[d] = 1'b0;
    chk("busy_after_start", busy_w[d], 1'b1);
    chk("valid_after_start", valid_w[d], 1'b0);
    chk("add1_win0", a1_w[d], rep5(0));
    chk("add2_win0", a2_w[d], rep5(1));
    chk("add3_win0", a3_w[d], rep5(mapw));
    chk("add4_win0", a4_w[d], rep5(mapw + 1));
    t = 1; nvec = 0; stalls = 0; last_t = -1;
    was_stall = 0; finished = 0;
    held_data = '0; held_a1 = '0; held_last = 1'b0;
    while (!finished && t < 200) begin
      case (mode)
        0: ready_r[d] = 1'b1;
        1: ready_r[d] = !(t >= 2 && t <= 4);
        default: ready_r[d] = 1'($urandom_range(0, 1));
      endcase
      if (restart && t == 3) start_r[d] = 1'b1;
      if (was_stall) begin
        chk("stall_valid", valid_w[d], 1'b1);
        chk("stall_data", data_w[d], held_data);
        chk("stall_add1", a1_w[d], held_a1);
        chk("stall_last", last_w[d], held_last);
      end
      was_stall = 0;
      if (valid_w[d]) begin
        if (ready_r[d]) begin
          chk("vec_data", data_w[d], exp_vec(d, nvec));
          chk("vec_last", last_w[d], (nvec == nwin - 1));
          got.push_back(data_w[d]);
          if (nvec == nwin - 1) begin
            last_t = t;
            chk("last_time", t, nwin + 1 + stalls);
          end
          nvec++;
        end else begin
          if (mode == 1 && nvec == 0) chk("bp_add1_next", a1_w[d], rep5(2));
          stalls++;
          was_stall = 1;
          held_data = data_w[d];
          held_a1   = a1_w[d];
          held_last = last_w[d];
        end
      end
      if (done_w[d]) begin
        chk("done_time", t, last_t + 1);
        chk("nvec_at_done", nvec, nwin);
        chk("valid_at_done", valid_w[d], 1'b0);
        if (restart) start_r[d] = 1'b1;
        finished = 1;
      end
      tick();
      start_r[d] = 1'b0;
      t++;
    end
    if (!finished) chk("done_timeout", 1'b0, finished);
    chk("busy_after_done", busy_w[d], 1'b0);
    chk("done_one_pulse", done_w[d], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("quiet_valid", valid_w[d], 1'b0);
      chk("quiet_busy", busy_w[d], 1'b0);
      chk("quiet_done", done_w[d], 1'b0);
    end
    ready_r[d] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int walk8[8];
    int walk4[8];
    logic [7:0] b;
    logic [7:0] neg_exp;
    int nhs, guard;

    walk8 = '{9, 11, 13, 15, 25, 27, 29, 31};
    walk4 = '{5, 7, 13, 15, 21, 23, 29, 31};
    nrst = 1'b0;
    start_r = '0;
    ready_r = '1;
    fill_index(0);
    fill_index(1);
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", valid_w[d], 1'b0);
      chk("rst_last", last_w[d], 1'b0);
      chk("rst_busy", busy_w[d], 1'b0);
      chk("rst_done", done_w[d], 1'b0);
      chk("rst_data", data_w[d], 32'h0);
      chk("rst_add1", a1_w[d], 20'h0);
      chk("rst_add2", a2_w[d], 20'h0);
      chk("rst_add3", a3_w[d], 20'h0);
      chk("rst_add4", a4_w[d], 20'h0);
    end
    nrst = 1'b1;
    tick();

    // Tile walk with entry k = k
    run_tile(0, 0, 1'b0);
    chk("walk_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      b = 8'(walk8[i]);
      chk("walk_vec", got[i], {4{b}});
    end

    // Signed max
    fill_random(0);
    rf[0][0][0] = 8'(-5);   rf[0][1][0] = 8'(-2);
    rf[0][8][0] = 8'(-128); rf[0][9][0] = 8'(-7);
    rf[0][0][1] = 8'd127;   rf[0][1][1] = 8'(-1);
    rf[0][8][1] = 8'd0;     rf[0][9][1] = 8'd3;
`ifdef OBUF_POOL_RELU_EN
    neg_exp = 8'd0;
`else
    neg_exp = 8'hfe;
`endif
    run_tile(0, 0, 1'b0);
    if (got.size() > 0) begin
      chk("smax_neg", got[0][7:0], neg_exp);
      chk("smax_pos", got[0][15:8], 8'd127);
    end else begin
      chk("smax_novec", got.size(), 8);
    end

    // Backpressure
    fill_index(0);
    run_tile(0, 1, 1'b0);
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      b = 8'(walk8[i]);
      chk("bp_vec", got[i], {4{b}});
    end

    // Start ignored while busy and on the done cycle
    fill_random(0);
    run_tile(0, 0, 1'b1);
    chk("restart_count", got.size(), 8);

    // Reset mid-run
    fill_random(0);
    ready_r[0] = 1'b1;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    nhs = 0;
    guard = 0;
    while (nhs < 4 && guard < 50) begin
      if (valid_w[0] && ready_r[0]) nhs++;
      tick();
      guard++;
    end
    chk("rst_mid_reach", nhs, 4);
    nrst = 1'b0;
    tick();
    chk("rst_mid_valid", valid_w[0], 1'b0);
    chk("rst_mid_busy", busy_w[0], 1'b0);
    chk("rst_mid_add1", a1_w[0], 20'h0);
    chk("rst_mid_last", last_w[0], 1'b0);
    chk("rst_mid_done", done_w[0], 1'b0);
    nrst = 1'b1;
    tick();
    run_tile(0, 0, 1'b0);
    chk("rst_mid_rerun", got.size(), 8);

    // Alternate geometry MAP_W=4
    fill_index(1);
    run_tile(1, 0, 1'b0);
    chk("geo4_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      b = 8'(walk4[i]);
      chk("geo4_vec", got[i], {4{b}});
    end

    // Random data with random backpressure
    for (int r = 0; r < 3; r++) begin
      fill_random(1);
      run_tile(1, 2, 1'b0);
      fill_random(0);
      run_tile(0, 2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
